accum_window: RTL and testbench

Parametrised windowed accumulator. Sums a programmable number of input samples (win_len) and emits one result per window through a valid/ready output. It adds signed/unsigned operation, saturating or wrapping arithmetic, an overflow flag, a window flush and backpressure, none of which the earlier fixed 8-bit free-running accumulator had. It sits between sample producers and downstream averaging/decimation logic.

---
 rtl/accum_window.sv | 118 +++++++++++
 tb/tb_accum_window.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/accum_window.sv
// accum_window: windowed accumulator, one valid/ready result per win_len samples.
//   clk, reset (sync, active-low), clear (flush partial window / pending result)
//   win_len, in_valid, in_data, in_ready : sample input side
//   out_valid, out_data, out_ovf, out_ready : result output side
//   busy : window in progress
module accum_window #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int CNT_W    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    input  logic              out_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d, new_acc, sat_val, base;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_next, len_cur;
    logic ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [ACC_W:0] acc_x, in_x, sum;
    logic in_xfer, out_xfer, ovf_now, new_ovf, done, out_free;
    assign in_ready  = reset & ~clear & (state_q != HOLD);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;
    assign out_free  = ~out_valid_q | out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = state_q != IDLE;
    always_comb begin
        // A new window starts from zero regardless of leftover accumulator contents.
        base     = (state_q == IDLE) ? '0 : acc_q;
        acc_x    = (SIGNED != 0) ? {base[ACC_W-1], base} : {1'b0, base};
        in_x     = {{(ACC_W+1-DATA_W){(SIGNED != 0) ? in_data[DATA_W-1] : 1'b0}}, in_data};
        sum      = acc_x + in_x;
        ovf_now  = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        // Guard bit carries the sign of the true sum, choosing max or min.
        sat_val  = (SIGNED != 0) ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : '1;
        new_acc  = (ovf_now && SATURATE != 0) ? sat_val : sum[ACC_W-1:0];
        new_ovf  = ((state_q == IDLE) ? 1'b0 : ovf_q) | ovf_now;
        cnt_next = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        len_cur  = (state_q != IDLE) ? len_q : (win_len == '0) ? CNT_W'(1) : win_len;
        done     = in_xfer && (cnt_next == len_cur);
    end
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == HOLD) begin
            if (out_xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_q;
                out_ovf_d   = ovf_q;
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
            end
        end else if (in_xfer) begin
            acc_d   = new_acc;
            cnt_d   = cnt_next;
            len_d   = len_cur;
            ovf_d   = new_ovf;
            state_d = ACCUM;
            if (done && out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = new_acc;
                out_ovf_d   = new_ovf;
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
            end else if (done) begin
                state_d = HOLD;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_accum_window.sv
// tb_accum_window: four accum_window configurations driven in lockstep against a value-level model.
module tb_accum_window;
    logic clk = 1'b0;
    logic reset = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0, win_len = '0;
    logic ir[4], ov[4], oo[4], bz[4];
    logic [15:0] od[4];
    logic [15:0] od0;
    logic [7:0] od1, od2, od3;
    int n_chk = 0, n_bad = 0;
    int cw[4] = '{16, 8, 8, 8};
    bit cs[4] = '{0, 0, 0, 1};
    bit csat[4] = '{1, 1, 0, 1};
    longint m_acc[4], m_od[4];
    bit m_ovf[4], m_oo[4];
    int m_n = 0, m_len = 0;
    bit m_hold = 0, m_ov = 0;
    always #5 clk = ~clk;
    accum_window u0 (.clk(clk), .reset(reset), .clear(clear), .win_len(win_len), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od0), .out_ovf(oo[0]), .out_ready(out_ready), .busy(bz[0]));
    accum_window #(.ACC_W(8)) u1 (.clk(clk), .reset(reset), .clear(clear), .win_len(win_len), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od1), .out_ovf(oo[1]), .out_ready(out_ready), .busy(bz[1]));
    accum_window #(.ACC_W(8), .SATURATE(0)) u2 (.clk(clk), .reset(reset), .clear(clear), .win_len(win_len), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od2), .out_ovf(oo[2]), .out_ready(out_ready), .busy(bz[2]));
    accum_window #(.ACC_W(8), .SIGNED(1)) u3 (.clk(clk), .reset(reset), .clear(clear), .win_len(win_len), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od3), .out_ovf(oo[3]), .out_ready(out_ready), .busy(bz[3]));
    assign od[0] = od0;
    assign od[1] = {8'h0, od1};
    assign od[2] = {8'h0, od2};
    assign od[3] = {8'h0, od3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Mathematical sum with clamping or modular wrap over the configuration's range.
    task automatic add(input int i, input logic [7:0] d);
        longint x, t, hi, lo, span;
        span = longint'(1) << cw[i];
        x  = cs[i] ? longint'($signed(d)) : longint'(d);
        hi = cs[i] ? span / 2 - 1 : span - 1;
        lo = cs[i] ? -(span / 2) : 0;
        t  = m_acc[i] + x;
        if (t > hi || t < lo) begin
            m_ovf[i] = 1;
            if (csat[i]) t = (t > hi) ? hi : lo;
            else begin
                t = t & (span - 1);
                if (cs[i] && t > hi) t = t - span;
            end
        end
        m_acc[i] = t;
    endtask

    task automatic update(input bit r, c, v, input logic [7:0] d, w, input bit o);
        bit ox, ix, nov;
        if (!r) begin
            m_n = 0; m_len = 0; m_hold = 0; m_ov = 0;
            for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_ovf[i] = 0; m_od[i] = 0; m_oo[i] = 0; end
            return;
        end
        ox  = m_ov & o;
        ix  = v & !c & !m_hold;
        nov = m_ov & !o;
        if (c) begin
            m_n = 0; m_hold = 0;
            for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
        end else if (m_hold) begin
            if (ox) begin
                for (int i = 0; i < 4; i++) begin m_od[i] = m_acc[i]; m_oo[i] = m_ovf[i]; m_acc[i] = 0; end
                nov = 1; m_hold = 0; m_n = 0;
            end
        end else if (ix) begin
            if (m_n == 0) begin
                m_len = (w == 0) ? 1 : int'(w);
                for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
            end
            for (int i = 0; i < 4; i++) add(i, d);
            m_n++;
            if (m_n == m_len) begin
                if (!m_ov || o) begin
                    for (int i = 0; i < 4; i++) begin m_od[i] = m_acc[i]; m_oo[i] = m_ovf[i]; m_acc[i] = 0; end
                    nov = 1; m_n = 0;
                end else m_hold = 1;
            end
        end
        m_ov = nov;
    endtask

    task automatic step(input bit r, c, v, input logic [7:0] d, w, input bit o);
        @(negedge clk);
        reset = r; clear = c; in_valid = v; in_data = d; win_len = w; out_ready = o;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d_in_ready", i), 32'(ir[i]), 32'(r & !c & !m_hold));
            check($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(m_ov));
            check($sformatf("u%0d_out_data", i), 32'(od[i]), 32'(m_od[i] & ((longint'(1) << cw[i]) - 1)));
            check($sformatf("u%0d_out_ovf", i), 32'(oo[i]), 32'(m_oo[i]));
            check($sformatf("u%0d_busy", i), 32'(bz[i]), 32'(m_n != 0 || m_hold));
        end
        update(r, c, v, d, w, o);
    endtask

    initial begin
        int pct;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("reset_data", 32'(od0), 0);
        step(1, 0, 1, 10, 4, 1); step(1, 0, 1, 20, 4, 1); step(1, 0, 1, 30, 4, 1); step(1, 0, 1, 40, 4, 1);
        step(1, 0, 0, 0, 4, 1);
        check("p1_valid", 32'(ov[0]), 1);
        check("p1_sum", 32'(od0), 100);
        check("p1_busy", 32'(bz[0]), 0);
        step(1, 0, 1, 200, 3, 1); step(1, 0, 1, 100, 3, 1); step(1, 0, 1, 5, 3, 1);
        step(1, 0, 0, 0, 3, 1);
        check("p2_sat", 32'(od1), 255);
        check("p2_sat_ovf", 32'(oo[1]), 1);
        check("p2_wrap", 32'(od2), 49);
        check("p2_wrap_ovf", 32'(oo[2]), 1);
        step(1, 0, 1, 8'h9c, 2, 1); step(1, 0, 1, 8'h9c, 2, 1);
        step(1, 0, 0, 0, 2, 1);
        check("p3_min", 32'(od3), 32'h80);
        check("p3_min_ovf", 32'(oo[3]), 1);
        step(1, 0, 1, 50, 2, 1); step(1, 0, 1, 8'hec, 2, 1);
        step(1, 0, 0, 0, 2, 1);
        check("p3_sum", 32'(od3), 30);
        check("p3_sum_ovf", 32'(oo[3]), 0);
        step(1, 0, 1, 7, 1, 0); step(1, 0, 1, 9, 1, 0); step(1, 0, 1, 11, 1, 0);
        check("p4_hold_ready", 32'(ir[0]), 0);
        check("p4_held", 32'(od0), 7);
        step(1, 0, 0, 0, 1, 1); step(1, 0, 0, 0, 1, 1);
        check("p4_reload", 32'(od0), 9);
        check("p4_reload_valid", 32'(ov[0]), 1);
        step(1, 0, 0, 0, 1, 1);
        check("p4_drain_valid", 32'(ov[0]), 0);
        check("p4_drain_ready", 32'(ir[0]), 1);
        step(1, 0, 1, 5, 4, 1); step(1, 0, 1, 5, 4, 1); step(1, 1, 1, 5, 4, 1);
        check("p5_clear_ready", 32'(ir[0]), 0);
        step(1, 0, 1, 1, 4, 1); step(1, 0, 1, 2, 4, 1); step(1, 0, 1, 3, 4, 1); step(1, 0, 1, 4, 4, 1);
        step(1, 0, 0, 0, 4, 1);
        check("p5_sum", 32'(od0), 10);
        step(1, 0, 1, 3, 1, 0); step(1, 0, 1, 4, 1, 0); step(1, 1, 0, 0, 1, 0); step(1, 0, 0, 0, 1, 0);
        check("p5_hold_cleared_data", 32'(od0), 3);
        check("p5_hold_cleared_busy", 32'(bz[0]), 0);
        step(1, 0, 1, 1, 4, 0); step(1, 0, 1, 2, 4, 0); step(0, 0, 1, 3, 4, 0); step(1, 0, 0, 0, 0, 1);
        check("p6_reset_valid", 32'(ov[0]), 0);
        check("p6_reset_busy", 32'(bz[0]), 0);
        step(1, 0, 1, 77, 0, 1); step(1, 0, 1, 88, 0, 1);
        check("p6_single", 32'(od0), 77);
        step(1, 0, 0, 0, 0, 1);
        check("p6_single2", 32'(od0), 88);
        pct = 80;
        for (int k = 0; k < 6000; k++) begin
            if (k % 500 == 0) pct = int'($urandom_range(10, 100));
            step($urandom_range(0, 299) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 8'($urandom), ($urandom_range(0, 127) == 0) ? 8'd255 : 8'($urandom_range(0, 6)),
                 int'($urandom_range(0, 99)) < pct);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
